// File: rtl/axi_reg_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axi_reg_read_ctrl
//  Description : AXI4-Lite read-channel controller for an 8-entry register
//                read mux. Latches the AR address onto the mux select, issues a
//                one-cycle read strobe for aligned accesses, captures the mux
//                output and returns it on R with backpressure. Counts OKAY and
//                SLVERR completions with saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_reg_read_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int OPT_MEM_ADDR_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] mux_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] mux_data,
    output logic                          rd_strobe,
    output logic [2:0]                    rd_index,
    output logic [15:0]                   rd_count,
    output logic [7:0]                    err_count
);

    localparam int ADDR_LSB = C_S_AXI_DATA_WIDTH / 32 + 1;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                          r_state;
    logic                            r_arready;
    logic                            r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]                      r_rresp;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_mux_addr;
    logic                            r_rd_strobe;
    logic [2:0]                      r_rd_index;
    logic [15:0]                     r_rd_count;
    logic [7:0]                      r_err_count;

    // Alignment of the incoming address (decides the strobe) and of the
    // latched address (decides OKAY vs SLVERR).
    logic w_ar_aligned;
    logic w_q_aligned;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_ar_aligned = (s_axi_araddr[ADDR_LSB-1:0] == '0);
    assign w_q_aligned  = (r_mux_addr[ADDR_LSB-1:0] == '0);
    assign w_ar_hs      = s_axi_arvalid && r_arready;
    assign w_r_hs       = r_rvalid && s_axi_rready;

    // Single read-transaction FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= C_RESP_OKAY;
            r_mux_addr  <= '0;
            r_rd_strobe <= 1'b0;
            r_rd_index  <= 3'd0;
            r_rd_count  <= 16'd0;
            r_err_count <= 8'd0;
        end else begin
            // Strobe is a single-cycle pulse covering only the DECODE cycle.
            r_rd_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_mux_addr  <= s_axi_araddr;
                        r_arready   <= 1'b0;
                        r_rd_strobe <= w_ar_aligned;
                        if (w_ar_aligned) begin
                            r_rd_index <= 3'(s_axi_araddr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB]);
                        end
                        r_state     <= S_DECODE;
                    end else begin
                        // arready comes up one cycle after reset release.
                        r_arready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    // mux_data reflects r_mux_addr during this cycle.
                    r_rvalid <= 1'b1;
                    if (w_q_aligned) begin
                        r_rdata <= mux_data;
                        r_rresp <= C_RESP_OKAY;
                    end else begin
                        r_rdata <= '0;
                        r_rresp <= C_RESP_SLVERR;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_r_hs) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        if (r_rresp == C_RESP_OKAY) begin
                            if (r_rd_count != 16'hFFFF) begin
                                r_rd_count <= r_rd_count + 16'd1;
                            end
                        end else begin
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign mux_addr      = r_mux_addr;
    assign rd_strobe     = r_rd_strobe;
    assign rd_index      = r_rd_index;
    assign rd_count      = r_rd_count;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_reg_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_reg_read_ctrl
//  Description : Directed, table-driven bench for axi_reg_read_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_reg_read_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [4:0]  mux_addr;
    logic [31:0] mux_data;
    logic        rd_strobe;
    logic [2:0]  rd_index;
    logic [15:0] rd_count;
    logic [7:0]  err_count;

    int n_checks;
    int n_errors;
    int exp_rd;
    int exp_err;

    axi_reg_read_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .OPT_MEM_ADDR_BITS  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .mux_addr      (mux_addr),
        .mux_data      (mux_data),
        .rd_strobe     (rd_strobe),
        .rd_index      (rd_index),
        .rd_count      (rd_count),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          delay;
        logic        exp_strobe;
        logic [2:0]  exp_idx;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic upd_counts(input logic [1:0] resp);
        if (resp == 2'b00) begin
            if (exp_rd < 16'hFFFF) exp_rd++;
        end else begin
            if (exp_err < 8'hFF) exp_err++;
        end
    endtask

    // One complete read; called at a negedge with the FSM idle.
    task automatic do_read(input vec_t v);
        logic [31:0] held;
        chk("arready_idle", {31'd0, arready}, 32'd1);
        arvalid  = 1'b1;
        araddr   = v.addr;
        mux_data = v.data;
        rready   = (v.delay == 0);
        @(negedge clk);                       // DECODE (T+1)
        arvalid = 1'b0;
        araddr  = ~v.addr;
        chk("mux_addr", {27'd0, mux_addr}, {27'd0, v.addr});
        chk("rd_strobe", {31'd0, rd_strobe}, {31'd0, v.exp_strobe});
        if (v.exp_strobe) chk("rd_index", {29'd0, rd_index}, {29'd0, v.exp_idx});
        chk("arready_busy", {31'd0, arready}, 32'd0);
        @(negedge clk);                       // RESP (T+2)
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk("rdata", rdata, v.exp_rdata);
        chk("rresp", {30'd0, rresp}, {30'd0, v.exp_rresp});
        held = rdata;
        for (int i = 0; i < v.delay; i++) begin
            mux_data = $urandom;
            arvalid  = 1'b1;                  // must be ignored while busy
            araddr   = 5'($urandom);
            @(negedge clk);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("rdata_hold", rdata, held);
            chk("mux_addr_hold", {27'd0, mux_addr}, {27'd0, v.addr});
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);                       // R+1
        upd_counts(v.exp_rresp);
        chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
        chk("arready_back", {31'd0, arready}, 32'd1);
        chk("rd_count", {16'd0, rd_count}, exp_rd);
        chk("err_count", {24'd0, err_count}, exp_err);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_rd  = 0;
        exp_err = 0;
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_mux_addr", {27'd0, mux_addr}, 32'd0);
        chk("rst_strobe", {31'd0, rd_strobe}, 32'd0);
        chk("rst_index", {29'd0, rd_index}, 32'd0);
        chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("arready_after_rst", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        exp_rd   = 0;
        exp_err  = 0;
        reset    = 1'b1;
        arvalid  = 1'b0;
        araddr   = 5'd0;
        rready   = 1'b0;
        mux_data = 32'd0;

        vecs[0] = '{5'h08, 32'hDEADBEEF, 0, 1'b1, 3'd2, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{5'h1C, 32'h12345678, 5, 1'b1, 3'd7, 32'h12345678, 2'b00};
        vecs[2] = '{5'h05, 32'h55555555, 0, 1'b0, 3'd0, 32'h00000000, 2'b10};
        vecs[3] = '{5'h00, 32'hA5A5A5A5, 1, 1'b1, 3'd0, 32'hA5A5A5A5, 2'b00};
        vecs[4] = '{5'h13, 32'hFFFFFFFF, 2, 1'b0, 3'd0, 32'h00000000, 2'b10};
        vecs[5] = '{5'h14, 32'hCAFEF00D, 2, 1'b1, 3'd5, 32'hCAFEF00D, 2'b00};
        vecs[6] = '{5'h02, 32'h0BADF00D, 0, 1'b0, 3'd0, 32'h00000000, 2'b10};

        @(negedge clk);
        apply_reset();

        for (int i = 0; i < 7; i++) do_read(vecs[i]);

        // Eight back-to-back aligned reads with rready held high.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            v = '{5'(i * 4), 32'h1000_0000 + 32'(i), 0, 1'b1, 3'(i),
                  32'h1000_0000 + 32'(i), 2'b00};
            do_read(v);
        end
        chk("b2b_rd_count", {16'd0, rd_count}, 32'd8);

        // Reset asserted while the response is pending.
        rready  = 1'b0;
        arvalid = 1'b1;
        araddr  = 5'h0C;
        mux_data = 32'h77777777;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_rd_count", {16'd0, rd_count}, 32'd0);
        chk("midrst_arready", {31'd0, arready}, 32'd0);
        apply_reset();
        do_read(vecs[0]);

        // Reset asserted during DECODE: strobe must not survive.
        arvalid = 1'b1;
        araddr  = 5'h10;
        rready  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("dec_strobe", {31'd0, rd_strobe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("decrst_strobe", {31'd0, rd_strobe}, 32'd0);
        chk("decrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("decrst_rd_count", {16'd0, rd_count}, 32'd0);
        apply_reset();

        // rd_count saturation from a preloaded value.
        force dut.r_rd_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_rd_count;
        exp_rd = 16'hFFFE;
        chk("preload", {16'd0, rd_count}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) do_read(vecs[5]);
        chk("rd_sat", {16'd0, rd_count}, 32'h0000FFFF);

        // err_count saturation through real misaligned reads.
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            v = '{5'(i * 4 + 1), 32'(i), 0, 1'b0, 3'd0, 32'd0, 2'b10};
            do_read(v);
        end
        chk("err_sat", {24'd0, err_count}, 32'h000000FF);
        chk("err_sat_rd", {16'd0, rd_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_reg_read_ctrl.md
# axi_reg_read_ctrl

AXI4-Lite read-channel controller that sequences the 8-entry slave register read mux. It accepts read addresses on the AR channel and drives the latched address into the mux select. It captures the selected word and returns it on the R channel with full backpressure support. It also emits a one-cycle read strobe so clear-on-read registers can react, and counts completed and errored reads for debug.

## Interface

- Synchronous, active-high reset; single clock domain.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width of R channel and mux data input
- C_S_AXI_ADDR_WIDTH, 5, byte address width
- OPT_MEM_ADDR_BITS, 2, register index is ADDR_LSB+OPT_MEM_ADDR_BITS : ADDR_LSB, with ADDR_LSB = C_S_AXI_DATA_WIDTH/32 + 1 (= 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read byte address
- s_axi_arvalid  in  1  address valid
- s_axi_arready  out  1  address ready
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data
- s_axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  master ready
- mux_addr  out  C_S_AXI_ADDR_WIDTH  latched address to the register mux select
- mux_data  in  C_S_AXI_DATA_WIDTH  combinational mux output for mux_addr
- rd_strobe  out  1  one-cycle pulse when a valid register is read
- rd_index  out  3  register index qualified by rd_strobe
- rd_count  out  16  completed OKAY reads, saturating
- err_count  out  8  completed SLVERR reads, saturating

## Operation

- FSM states: IDLE, DECODE, RESP.
- IDLE:
  - s_axi_arready = 1.
  - On arvalid && arready: latch araddr into addr_q and go to DECODE.
- DECODE (exactly one cycle):
  - mux_addr = addr_q.
  - If addr_q[1:0] == 0: assert rd_strobe, set rd_index = addr_q[4:2].
  - On exit: rdata <= mux_data, rresp <= OKAY, rvalid <= 1.
  - If addr_q[1:0] != 0 (misaligned): no strobe, rdata <= 0, rresp <= SLVERR, rvalid <= 1.
  - Go to RESP.
- RESP:
  - Hold rvalid, rdata and rresp stable until rready.
  - On rvalid && rready: rvalid <= 0; increment rd_count (OKAY) or err_count (SLVERR); go to IDLE.
- Only one outstanding read; arready = 0 in DECODE and RESP, and arvalid is ignored there.
- mux_addr holds addr_q in every state; it changes only on an AR handshake.
- Counters saturate at all-ones (16'hFFFF, 8'hFF) and never wrap.

## Timing

- Reset values:
  - state IDLE.
  - s_axi_arready 0; it goes to 1 in the first cycle after reset deasserts.
  - rvalid 0, rdata 0, rresp 0.
  - mux_addr 0, rd_strobe 0, rd_index 0, rd_count 0, err_count 0.
- Latency: AR handshake in cycle T → rd_strobe in T+1 → rvalid = 1 in T+2.
- R handshake in cycle R → rvalid = 0 and arready = 1 in R+1. The next AR handshake is possible at R+1.
- Back-to-back throughput with rready held high is one read per 3 cycles.
- rready already high when rvalid rises: the handshake completes in T+2.
- Reset asserted mid-transaction (DECODE or RESP): all outputs take reset values on the next edge. No strobe is issued and no counter increments.
- arvalid dropped before arready (protocol violation) is harmless; the FSM acts only on the handshake cycle.

## Test plan

- Reset, then read 0x08 with mux_data = 32'hDEADBEEF → rd_strobe in T+1 with rd_index = 2; rvalid in T+2 with rdata = 32'hDEADBEEF and rresp = 0; rd_count = 1.
- Read 0x1C with rready held low for 5 cycles and mux_data changing every cycle → rdata stays at the value sampled in DECODE; handshake completes when rready rises; arready returns one cycle later.
- Read 0x05 (misaligned) → no rd_strobe, rdata = 0, rresp = 2'b10, err_count = 1, rd_count unchanged.
- Eight back-to-back reads 0x00..0x1C with rready = 1 → each response 3 cycles apart, rd_index sequence 0..7, rd_count = 8.
- Assert reset in the RESP cycle → rvalid = 0 and counters = 0 next cycle; after release, arready = 1 and a fresh read works.
- Preload rd_count to 16'hFFFE (force), then perform 3 reads → counter reads 16'hFFFF and stays there.
